// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory block.
// Holds the boot-loader state encoding, the load base address and the
// memory depth helper used by the top and by the RAM.
package data_memory_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LEN,
    LOAD_DATA,
    LOAD_SUM,
    RUN,
    ERROR
  } ld_state_t;

  localparam int LOAD_BASE      = 0;
  localparam int DEF_ADDR_WIDTH = 6;

  function automatic int mem_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int MEM_DEPTH = mem_depth(DEF_ADDR_WIDTH);

endpackage

// File: rtl/data_memory_ram_sp.sv
// ram_sp: single-port synchronous RAM, write-first, registered read.
// Ports:
//   clk   - clock, all activity on posedge
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   q     - registered read data (shows wdata on a write cycle)
// The array has no reset; contents persist across rst_n.
module ram_sp
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] ram [mem_depth(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
      q         <= wdata;
    end else begin
      q         <= ram[addr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// data_memory: 64x16 CPU data/program memory with a streaming boot loader.
// After reset a length-prefixed image is accepted over ld_valid/ld_ready and
// written from address 0; the CPU is then released through cpu_rst_n.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   addr, data, we       - CPU port (MAR/MDR), honoured only in RUN
//   mem                  - registered read data to CPU, 0 while not running
//   ld_valid, ld_data    - loader word stream
//   ld_ready             - loader can accept a word
//   ld_done              - image loaded, CPU running
//   ld_err               - load failed, sticky until rst_n
//   cpu_rst_n            - registered active-low CPU reset
// Optional feature: DATA_MEMORY_CHECKSUM_EN adds a trailing XOR checksum word.
//
// state     | meaning
// IDLE      | one cycle after reset
// LOAD_LEN  | waiting for length word N
// LOAD_DATA | writing N words from address 0
// LOAD_SUM  | waiting for checksum word (checksum build only)
// RUN       | CPU owns the RAM port
// ERROR     | bad length or checksum, CPU held in reset
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] mem,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_err,
  output logic                  cpu_rst_n
);

  localparam logic [DATA_WIDTH-1:0] LEN_MAX = DATA_WIDTH'(mem_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   REM_ONE = (ADDR_WIDTH+1)'(1);

  ld_state_t             state, state_nx;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  xfer;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_q;
`ifdef DATA_MEMORY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  assign ld_ready = (state == LOAD_LEN) || (state == LOAD_DATA) || (state == LOAD_SUM);
  assign xfer     = ld_valid && ld_ready;
  assign ld_err   = (state == ERROR);

  // cpu_rst_n is the registered copy of "in RUN", so it also marks cycles
  // where ram_q was captured from a CPU address.
  assign mem = cpu_rst_n ? ram_q : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = LOAD_LEN;
      LOAD_LEN: if (xfer) begin
        if (ld_data == '0)
`ifdef DATA_MEMORY_CHECKSUM_EN
          state_nx = LOAD_SUM;
`else
          state_nx = RUN;
`endif
        else if (ld_data > LEN_MAX)
          state_nx = ERROR;
        else
          state_nx = LOAD_DATA;
      end
      LOAD_DATA: if (xfer && remaining == REM_ONE) begin
`ifdef DATA_MEMORY_CHECKSUM_EN
        state_nx = LOAD_SUM;
`else
        state_nx = RUN;
`endif
      end
`ifdef DATA_MEMORY_CHECKSUM_EN
      LOAD_SUM: if (xfer) state_nx = (ld_data == csum) ? RUN : ERROR;
`else
      LOAD_SUM: state_nx = ERROR;
`endif
      RUN:      state_nx = RUN;
      ERROR:    state_nx = ERROR;
      default:  state_nx = IDLE;
    endcase
  end

  // Loader and CPU never own the port at the same time, so a plain mux suffices.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr;
    ram_wdata = data;
    if (state == RUN) begin
      ram_we = we;
    end else if (state == LOAD_DATA) begin
      ram_we    = xfer;
      ram_addr  = wp;
      ram_wdata = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wp        <= '0;
      remaining <= '0;
      cpu_rst_n <= 1'b0;
      ld_done   <= 1'b0;
`ifdef DATA_MEMORY_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_nx;
      cpu_rst_n <= (state == RUN);
      ld_done   <= (state == RUN);
      if (state == LOAD_LEN && xfer) begin
        wp        <= ADDR_WIDTH'(LOAD_BASE);
        remaining <= ld_data[ADDR_WIDTH:0];
`ifdef DATA_MEMORY_CHECKSUM_EN
        csum      <= '0;
`endif
      end else if (state == LOAD_DATA && xfer) begin
        wp        <= wp + ADDR_WIDTH'(1);
        remaining <= remaining - REM_ONE;
`ifdef DATA_MEMORY_CHECKSUM_EN
        csum      <= csum ^ ld_data;
`endif
      end
    end
  end

  ram_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory (default and DATA_MEMORY_CHECKSUM_EN builds).
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] data = '0;
  logic        we = 1'b0;
  logic [15:0] mem;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_ready, ld_done, ld_err, cpu_rst_n;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef DATA_MEMORY_CHECKSUM_EN
  localparam int SUM_WORDS = 1;
`else
  localparam int SUM_WORDS = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .we(we), .mem(mem),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err), .cpu_rst_n(cpu_rst_n)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    ld_valid = 1'b0;
    we = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    ld_valid = 1'b1;
    ld_data = w;
    while (ld_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout word=%h ld_ready=%b exp=1", w, ld_ready);
    end else begin
      tick;
    end
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string nm);
    we = 1'b0;
    addr = a;
    tick;
    checks++;
    if (mem !== exp) begin failures++; $display("FAIL %s addr=%0d mem=%h exp=%h", nm, a, mem, exp); end
  endtask

  task automatic wait_run(input string nm, output int c);
    int n = 0;
    while (cpu_rst_n !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    c = cyc;
    checks++;
    if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL %s_run_timeout cpu_rst_n=%b exp=1", nm, cpu_rst_n); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    checks++; if (mem !== 16'h0)   begin failures++; $display("FAIL reset_mem got=%h exp=0000", mem); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_done !== 1'b0)  begin failures++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
    checks++; if (ld_err !== 1'b0)   begin failures++; $display("FAIL reset_ld_err got=%b exp=0", ld_err); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL reset_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    rst_n = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL idle_ld_ready got=%b exp=0", ld_ready); end
    tick;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL len_ld_ready got=%b exp=1", ld_ready); end
  endtask

  task automatic test_load3;
    int t0, tr;
    send(16'd3);
    t0 = cyc;
    checks++; if (mem !== 16'h0) begin failures++; $display("FAIL load3_mem_gated got=%h exp=0000", mem); end
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
`ifdef DATA_MEMORY_CHECKSUM_EN
    send(16'h0000);
`endif
    ld_valid = 1'b0;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL load3_ready_drop got=%b exp=0", ld_ready); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL load3_cpu_early got=%b exp=0", cpu_rst_n); end
    wait_run("load3", tr);
    checks++; if (tr - t0 != 4 + SUM_WORDS) begin failures++; $display("FAIL load3_latency got=%0d exp=%0d", tr - t0, 4 + SUM_WORDS); end
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL load3_ld_done got=%b exp=1", ld_done); end
    rd(6'd0, 16'h1111, "load3_rd0");
    rd(6'd1, 16'h2222, "load3_rd1");
    rd(6'd2, 16'h3333, "load3_rd2");
  endtask

  task automatic test_run_write;
    we = 1'b1; addr = 6'd8; data = 16'hABCD;
    tick;
    checks++; if (mem !== 16'hABCD) begin failures++; $display("FAIL write_first got=%h exp=abcd", mem); end
    we = 1'b0;
    rd(6'd8, 16'hABCD, "run_readback");
    we = 1'b1; addr = 6'd5; data = 16'h0505;
    tick;
    we = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    tick;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL run_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL run_ld_done got=%b exp=1", ld_done); end
    ld_valid = 1'b0;
    rd(6'd5, 16'h0505, "run_rd5");
    rd(6'd0, 16'h1111, "run_valid_ignored");
  endtask

  task automatic test_n0_cpu_ignored;
    do_reset;
    we = 1'b1; addr = 6'd5; data = 16'hDEAD;
    send(16'd0);
`ifdef DATA_MEMORY_CHECKSUM_EN
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL n0_needs_sum ld_ready=%b exp=1", ld_ready); end
    send(16'd0);
`endif
    we = 1'b0;
    ld_valid = 1'b0;
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL n0_cpu_early got=%b exp=0", cpu_rst_n); end
    tick;
    checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL n0_cpu_release got=%b exp=1", cpu_rst_n); end
    rd(6'd5, 16'h0505, "n0_cpu_write_ignored");
  endtask

  task automatic test_n65;
    do_reset;
    send(16'd65);
    ld_data = 16'h0001;
    checks++; if (ld_err !== 1'b1)   begin failures++; $display("FAIL n65_ld_err got=%b exp=1", ld_err); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL n65_ld_ready got=%b exp=0", ld_ready); end
    repeat (3) tick;
    checks++; if (ld_err !== 1'b1)    begin failures++; $display("FAIL n65_err_sticky got=%b exp=1", ld_err); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL n65_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    checks++; if (ld_done !== 1'b0)   begin failures++; $display("FAIL n65_ld_done got=%b exp=0", ld_done); end
    checks++; if (mem !== 16'h0)      begin failures++; $display("FAIL n65_mem got=%h exp=0000", mem); end
    ld_valid = 1'b0;
  endtask

  task automatic test_n64_back_to_back;
    int t0, tr;
    do_reset;
    send(16'd64);
    t0 = cyc;
    for (int i = 0; i < 64; i++) send(16'h4000 + 16'(i));
`ifdef DATA_MEMORY_CHECKSUM_EN
    send(16'h0000);
`endif
    ld_valid = 1'b0;
    checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL n64_ld_err got=%b exp=0", ld_err); end
    checks++; if (cyc - t0 != 64 + SUM_WORDS) begin failures++; $display("FAIL n64_throughput got=%0d exp=%0d", cyc - t0, 64 + SUM_WORDS); end
    wait_run("n64", tr);
    checks++; if (tr - t0 != 65 + SUM_WORDS) begin failures++; $display("FAIL n64_latency got=%0d exp=%0d", tr - t0, 65 + SUM_WORDS); end
    rd(6'd63, 16'h403F, "n64_rd63");
    rd(6'd0, 16'h4000, "n64_rd0");
    rd(6'd8, 16'h4008, "n64_rd8");
  endtask

  task automatic test_mid_reset;
    int tr;
    do_reset;
    send(16'd5);
    send(16'hA0A0);
    send(16'hB1B1);
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b0)  begin failures++; $display("FAIL mid_ld_ready got=%b exp=0", ld_ready); end
    checks++; if (ld_done !== 1'b0)   begin failures++; $display("FAIL mid_ld_done got=%b exp=0", ld_done); end
    checks++; if (ld_err !== 1'b0)    begin failures++; $display("FAIL mid_ld_err got=%b exp=0", ld_err); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL mid_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    checks++; if (mem !== 16'h0)      begin failures++; $display("FAIL mid_mem got=%h exp=0000", mem); end
    tick;
    rst_n = 1'b1;
    tick;
    send(16'd1);
    send(16'h5555);
`ifdef DATA_MEMORY_CHECKSUM_EN
    send(16'h5555);
`endif
    ld_valid = 1'b0;
    wait_run("mid", tr);
    rd(6'd0, 16'h5555, "mid_rd0");
    rd(6'd1, 16'hB1B1, "mid_rd1_partial");
    rd(6'd2, 16'h4002, "mid_rd2_kept");
  endtask

`ifdef DATA_MEMORY_CHECKSUM_EN
  task automatic test_checksum;
    do_reset;
    send(16'd2); send(16'h00F0); send(16'h0F00); send(16'h0FF0);
    ld_valid = 1'b0;
    tick;
    checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL sum_good_cpu got=%b exp=1", cpu_rst_n); end
    checks++; if (ld_err !== 1'b0)    begin failures++; $display("FAIL sum_good_err got=%b exp=0", ld_err); end
    do_reset;
    send(16'd2); send(16'h00F0); send(16'h0F00); send(16'h0FF1);
    ld_valid = 1'b0;
    tick;
    checks++; if (ld_err !== 1'b1)    begin failures++; $display("FAIL sum_bad_err got=%b exp=1", ld_err); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL sum_bad_cpu got=%b exp=0", cpu_rst_n); end
    checks++; if (ld_ready !== 1'b0)  begin failures++; $display("FAIL sum_bad_ready got=%b exp=0", ld_ready); end
  endtask
`endif

  initial begin
    test_reset;
    test_load3;
    test_run_write;
    test_n0_cpu_ignored;
    test_n65;
    test_n64_back_to_back;
    test_mid_reset;
`ifdef DATA_MEMORY_CHECKSUM_EN
    test_checksum;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
